// File: rtl/nn_inference_sequencer.sv
// Sequences the NeuralNetwork datapath over the on-chip sample memory.
// It runs one sample or a sweep of all samples, waits for the network's
// maxValid, and compares each maxIndex with the stored label. Pass and total
// counters feed the board display.
module nn_inference_sequencer #(
  parameter int inputMemSize  = 16,
  parameter int addressWidth  = $clog2(inputMemSize),
  parameter int timeoutCycles = 65536,
  parameter int countWidth    = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic                    abort,
  input  logic                    sweep,
  input  logic [addressWidth-1:0] sel_addr,
  input  logic [3:0]              label_in,
  output logic [addressWidth-1:0] mem_addr,
  output logic                    nn_valid,
  input  logic                    nn_out_valid,
  input  logic                    max_valid,
  input  logic [3:0]              max_index,
  output logic [3:0]              result_index,
  output logic                    result_match,
  output logic [countWidth-1:0]   pass_count,
  output logic [countWidth-1:0]   total_count,
  output logic                    busy,
  output logic                    done,
  output logic                    error
);

  localparam int TmoWidth = (timeoutCycles > 2) ? $clog2(timeoutCycles) : 1;
  localparam logic [TmoWidth-1:0]     TmoLast  = TmoWidth'(timeoutCycles - 1);
  localparam logic [addressWidth-1:0] AddrLast = addressWidth'(inputMemSize - 1);
  localparam logic [countWidth-1:0]   CountMax = '1;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_RUN, S_WAIT_MAX, S_CAPTURE, S_DONE
  } state_e;

  state_e                  state_q, state_d;
  logic                    start_q;
  logic                    sweep_q, sweep_d;
  logic [addressWidth-1:0] addr_q, addr_d;
  logic [3:0]              label_q, label_d;
  logic [3:0]              cap_q, cap_d;
  logic                    nn_valid_q, nn_valid_d;
  logic [3:0]              res_idx_q, res_idx_d;
  logic                    res_match_q, res_match_d;
  logic [countWidth-1:0]   pass_q, pass_d;
  logic [countWidth-1:0]   total_q, total_d;
  logic                    error_q, error_d;
  logic [TmoWidth-1:0]     tmo_q, tmo_d;
  logic                    start_edge;
  logic                    cap_match;

  // Next-state and datapath updates for the sequencer FSM.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned and no latch is inferred.
    state_d     = state_q;
    sweep_d     = sweep_q;
    addr_d      = addr_q;
    label_d     = label_q;
    cap_d       = cap_q;
    nn_valid_d  = nn_valid_q;
    res_idx_d   = res_idx_q;
    res_match_d = res_match_q;
    pass_d      = pass_q;
    total_d     = total_q;
    error_d     = error_q;
    tmo_d       = tmo_q;
    start_edge  = start & ~start_q;
    cap_match   = (cap_q == label_q);

    if (abort && (state_q != S_IDLE)) begin
      // Abort beats a start edge or a network response in the same cycle.
      state_d    = S_IDLE;
      nn_valid_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start_edge) begin
            sweep_d     = sweep;
            addr_d      = sweep ? '0 : sel_addr;
            pass_d      = '0;
            total_d     = '0;
            error_d     = 1'b0;
            res_match_d = 1'b0;
            state_d     = S_FETCH;
          end
        end
        S_FETCH: begin
          // Memory data for the new address is valid by the end of this cycle.
          label_d    = label_in;
          nn_valid_d = 1'b1;
          tmo_d      = '0;
          state_d    = S_RUN;
        end
        S_RUN: begin
          tmo_d = tmo_q + 1'b1;
          if (nn_out_valid) begin
            nn_valid_d = 1'b0;
            if (max_valid) begin
              cap_d   = max_index;
              state_d = S_CAPTURE;
            end else begin
              state_d = S_WAIT_MAX;
            end
          end else if (tmo_q == TmoLast) begin
            error_d    = 1'b1;
            nn_valid_d = 1'b0;
            state_d    = S_DONE;
          end
        end
        S_WAIT_MAX: begin
          tmo_d = tmo_q + 1'b1;
          if (max_valid) begin
            cap_d   = max_index;
            state_d = S_CAPTURE;
          end else if (tmo_q == TmoLast) begin
            error_d = 1'b1;
            state_d = S_DONE;
          end
        end
        S_CAPTURE: begin
          res_idx_d   = cap_q;
          res_match_d = cap_match;
          if (total_q != CountMax) total_d = total_q + 1'b1;
          if (cap_match && (pass_q != CountMax)) pass_d = pass_q + 1'b1;
          if (sweep_q && (addr_q != AddrLast)) begin
            addr_d  = addr_q + 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_DONE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State and datapath registers; everything clears on reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      start_q     <= 1'b0;
      sweep_q     <= 1'b0;
      addr_q      <= '0;
      label_q     <= '0;
      cap_q       <= '0;
      nn_valid_q  <= 1'b0;
      res_idx_q   <= '0;
      res_match_q <= 1'b0;
      pass_q      <= '0;
      total_q     <= '0;
      error_q     <= 1'b0;
      tmo_q       <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q     <= state_d;
      start_q     <= start;
      sweep_q     <= sweep_d;
      addr_q      <= addr_d;
      label_q     <= label_d;
      cap_q       <= cap_d;
      nn_valid_q  <= nn_valid_d;
      res_idx_q   <= res_idx_d;
      res_match_q <= res_match_d;
      pass_q      <= pass_d;
      total_q     <= total_d;
      error_q     <= error_d;
      tmo_q       <= tmo_d;
    end
  end

  assign mem_addr     = addr_q;
  assign nn_valid     = nn_valid_q;
  assign result_index = res_idx_q;
  assign result_match = res_match_q;
  assign pass_count   = pass_q;
  assign total_count  = total_q;
  assign error        = error_q;
  assign done         = (state_q == S_DONE);
  assign busy         = (state_q != S_IDLE) && (state_q != S_DONE);

endmodule

// File: tb/tb_nn_inference_sequencer.sv
// Bench for nn_inference_sequencer: a behavioural network model answers
// requests and pushes the expected result; a monitor pops and compares on
// every capture.
module tb_nn_inference_sequencer;

  localparam int MemSize = 4;
  localparam int AW      = 2;
  localparam int Tmo     = 64;
  localparam int CW      = 16;

  typedef struct packed {
    logic [3:0] idx;
    logic       match;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset_n, start, abort, sweep;
  logic [AW-1:0] sel_addr, mem_addr;
  logic [3:0]    label_in, result_index;
  logic          nn_valid, result_match, busy, done, error;
  logic          nn_out_valid = 1'b0;
  logic          max_valid = 1'b0;
  logic [3:0]    max_index = 4'hF;
  logic [CW-1:0] pass_count, total_count;

  logic [3:0]    labels [MemSize];
  logic [3:0]    answers [MemSize];
  exp_t          exp_q [$];
  logic [AW-1:0] addr_seen [$];

  int            net_lat = 5;
  int            net_gap = 0;
  bit            net_mute = 1'b0;
  int            net_cnt = 0;
  int            net_pend = -1;
  logic [3:0]    net_ans = 4'h0;
  logic [CW-1:0] last_total = '0;

  int            n_checks = 0;
  int            n_fail = 0;
  int            cyc, vcnt, busy_cnt;

  nn_inference_sequencer #(
    .inputMemSize (MemSize),
    .timeoutCycles(Tmo),
    .countWidth   (CW)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .abort       (abort),
    .sweep       (sweep),
    .sel_addr    (sel_addr),
    .label_in    (label_in),
    .mem_addr    (mem_addr),
    .nn_valid    (nn_valid),
    .nn_out_valid(nn_out_valid),
    .max_valid   (max_valid),
    .max_index   (max_index),
    .result_index(result_index),
    .result_match(result_match),
    .pass_count  (pass_count),
    .total_count (total_count),
    .busy        (busy),
    .done        (done),
    .error       (error)
  );

  always #5 clk = ~clk;

  // Label memory: data for the current address is valid well before the fetch edge.
  assign label_in = labels[mem_addr];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Network model: answers after net_lat cycles of nn_valid, max_valid net_gap cycles later.
  always @(negedge clk) begin
    exp_t e;
    nn_out_valid = 1'b0;
    max_valid    = 1'b0;
    max_index    = 4'hF;
    if (!reset_n) begin
      net_cnt  = 0;
      net_pend = -1;
    end else if (net_pend >= 0) begin
      if (net_pend == 0) begin
        max_valid = 1'b1;
        max_index = net_ans;
        net_pend  = -1;
      end else begin
        net_pend--;
      end
    end else if (nn_valid && !net_mute) begin
      net_cnt++;
      if (net_cnt == net_lat) begin
        net_cnt      = 0;
        net_ans      = answers[mem_addr];
        nn_out_valid = 1'b1;
        e.idx        = net_ans;
        e.match      = (net_ans == labels[mem_addr]);
        exp_q.push_back(e);
        if (net_gap == 0) begin
          max_valid = 1'b1;
          max_index = net_ans;
        end else begin
          net_pend = net_gap - 1;
        end
      end
    end else begin
      net_cnt = 0;
    end
  end

  // Scoreboard monitor: each completed sample must match the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (reset_n && (total_count == last_total + 1'b1)) begin
      check("sb_nonempty", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("sb_index", result_index, e.idx);
        check("sb_match", result_match, e.match);
      end
    end
    last_total = total_count;
  end

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int cycles, output int vhigh);
    cycles = 0;
    vhigh  = 0;
    while (!done && cycles < budget) begin
      if (nn_valid) vhigh++;
      if (addr_seen.size() == 0 || addr_seen[$] != mem_addr) addr_seen.push_back(mem_addr);
      @(negedge clk);
      cycles++;
    end
    check("done_seen", done, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    start = 0; abort = 0; sweep = 0; sel_addr = '0; reset_n = 0;
    labels  = '{4'd1, 4'd2, 4'd3, 4'd7};
    answers = '{4'd1, 4'd2, 4'd3, 4'd7};
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_nn_valid", nn_valid, 0);
    check("rst_error", error, 0);
    check("rst_total", total_count, 0);
    check("rst_pass", pass_count, 0);
    check("rst_result", result_index, 0);
    check("rst_addr", mem_addr, 0);
    reset_n = 1;
    @(negedge clk);

    // Single sample at address 3, 20-cycle network latency
    net_lat = 20; net_gap = 0; sweep = 0; sel_addr = 2'd3;
    pulse_start();
    check("t1_busy", busy, 1);
    check("t1_addr", mem_addr, 3);
    wait_done(200, cyc, vcnt);
    check("t1_cycles", cyc, 22);
    check("t1_nn_valid_len", vcnt, 20);
    check("t1_index", result_index, 7);
    check("t1_match", result_match, 1);
    check("t1_pass", pass_count, 1);
    check("t1_total", total_count, 1);
    check("t1_busy_done", busy, 0);

    // Sweep of all four samples, one wrong answer
    labels  = '{4'd1, 4'd2, 4'd3, 4'd4};
    answers = '{4'd1, 4'd2, 4'd0, 4'd4};
    net_lat = 5; sweep = 1;
    addr_seen.delete();
    pulse_start();
    wait_done(300, cyc, vcnt);
    check("t2_cycles", cyc, 28);
    check("t2_nn_valid_len", vcnt, 20);
    check("t2_total", total_count, 4);
    check("t2_pass", pass_count, 3);
    check("t2_index", result_index, 4);
    check("t2_addr_steps", addr_seen.size(), 4);
    for (int i = 0; i < addr_seen.size() && i < 4; i++) check("t2_addr_seq", addr_seen[i], i);

    // max_valid three cycles after nn_out_valid
    net_lat = 4; net_gap = 3; sweep = 0; sel_addr = 2'd1;
    pulse_start();
    wait_done(200, cyc, vcnt);
    check("t3_cycles", cyc, 9);
    check("t3_nn_valid_len", vcnt, 4);
    check("t3_index", result_index, 2);
    check("t3_match", result_match, 1);
    check("t3_total", total_count, 1);

    // Network never answers: timeout
    net_gap = 0; net_mute = 1; sel_addr = 2'd2;
    pulse_start();
    wait_done(300, cyc, vcnt);
    check("t4_cycles", cyc, 65);
    check("t4_nn_valid_len", vcnt, 64);
    check("t4_error", error, 1);
    check("t4_nn_valid", nn_valid, 0);
    check("t4_total", total_count, 0);
    check("t4_match", result_match, 0);
    check("t4_index_held", result_index, 2);

    // Abort during sample 2 of a sweep
    net_mute = 0; net_lat = 10; sweep = 1;
    pulse_start();
    check("t5_error_clr", error, 0);
    cyc = 0;
    while (!(mem_addr == 2'd1 && nn_valid) && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check("t5_reach_s2", cyc < 100, 1);
    repeat (3) @(negedge clk);
    abort = 1;
    @(negedge clk);
    abort = 0;
    check("t5_busy", busy, 0);
    check("t5_done", done, 0);
    check("t5_nn_valid", nn_valid, 0);
    check("t5_total", total_count, 1);
    check("t5_pass", pass_count, 1);
    check("t5_error", error, 0);
    repeat (2) @(negedge clk);
    check("t5_idle", busy, 0);
    pulse_start();
    check("t5_restart_total", total_count, 0);
    check("t5_restart_pass", pass_count, 0);
    wait_done(300, cyc, vcnt);
    check("t5_full_total", total_count, 4);
    check("t5_full_pass", pass_count, 3);

    // start held high, with a second rising edge while busy
    net_lat = 3; sweep = 0; sel_addr = 2'd0;
    start = 1;
    @(negedge clk);
    @(negedge clk);
    start = 0;
    @(negedge clk);
    start = 1;
    wait_done(100, cyc, vcnt);
    check("t6_cycles", cyc, 3);
    check("t6_total", total_count, 1);
    busy_cnt = 0;
    repeat (5) begin
      @(negedge clk);
      if (busy) busy_cnt++;
    end
    check("t6_no_restart", busy_cnt, 0);
    check("t6_done_hold", done, 1);
    start = 0;
    @(negedge clk);
    pulse_start();
    check("t6_restart_busy", busy, 1);
    wait_done(100, cyc, vcnt);
    check("t6_total2", total_count, 1);

    // Abort and start edge together in DONE: abort wins
    start = 1; abort = 1;
    @(negedge clk);
    start = 0; abort = 0;
    check("t7_done", done, 0);
    check("t7_busy", busy, 0);
    check("t7_total_hold", total_count, 1);
    @(negedge clk);

    // Reset mid-run clears everything
    net_lat = 30; sweep = 1;
    pulse_start();
    repeat (5) @(negedge clk);
    reset_n = 0;
    #1;
    check("t8_busy", busy, 0);
    check("t8_nn_valid", nn_valid, 0);
    check("t8_total", total_count, 0);
    check("t8_index", result_index, 0);
    @(negedge clk);
    reset_n = 1;
    repeat (2) @(negedge clk);

    check("sb_leftover", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/nn_inference_sequencer.md
Name: nn_inference_sequencer

Overview:
Controller that sequences the NeuralNetwork datapath over the on-chip input sample memory. It runs one sample or a sweep of all samples, and holds NNvalid-style requests until the network reports completion. For each sample it captures maxIndex and compares it with a stored label. It accumulates pass/total counters for display on HEX/LEDR. It sits between the board switches/keys and the NeuralNetwork instance, replacing the ad-hoc start latch in top.

Parameters:
inputMemSize, 16, number of samples in input/label memories
addressWidth, $clog2(inputMemSize), sample address width
timeoutCycles, 65536, max cycles allowed from request to maxValid before error
countWidth, 16, width of pass/total counters

Ports:
clk  input  1  system clock (CLOCK_50 at top)
reset_n  input  1  asynchronous active-low reset
start  input  1  run request, level; rising edge detected internally
abort  input  1  synchronous abort, level
sweep  input  1  0 = single sample at sel_addr, 1 = all samples 0..inputMemSize-1; sampled on start edge
sel_addr  input  addressWidth  sample index for single mode; sampled on start edge
label_in  input  4  expected class from label memory; valid 1 cycle after mem_addr changes
mem_addr  output  addressWidth  address to input and label memories
nn_valid  output  1  request to NeuralNetwork (NNvalid)
nn_out_valid  input  1  NNoutValid from network
max_valid  input  1  maxValid from network
max_index  input  4  maxIndex from network
result_index  output  4  last captured maxIndex
result_match  output  1  last result_index == label
pass_count  output  countWidth  samples with match since run start
total_count  output  countWidth  samples completed since run start
busy  output  1  high in any state except IDLE/DONE
done  output  1  high in DONE
error  output  1  timeout occurred in the current/last run

Behaviour:
- Reset (async, reset_n=0): state IDLE; all outputs 0; start edge register 0; timeout counter 0.
- States: IDLE, FETCH, RUN, WAIT_MAX, CAPTURE, DONE.
- Start edge = start & ~start_q. Accepted in IDLE or DONE only; ignored while busy.
- On start edge: latch sweep; mem_addr <= sweep ? 0 : sel_addr; clear pass_count, total_count, error, result_match; go to FETCH.
- FETCH: 1 cycle for memory latency; latch label_in at end of cycle; go to RUN.
- RUN: nn_valid=1 (registered, high from first RUN cycle). On nn_out_valid: nn_valid<=0 next cycle. If max_valid is also high that cycle, go to CAPTURE; else go to WAIT_MAX.
- WAIT_MAX: nn_valid=0; on max_valid go to CAPTURE.
- Timeout: counter clears on entering RUN and increments each RUN/WAIT_MAX cycle. At timeoutCycles-1 without completion: error<=1, nn_valid<=0, go to DONE. Counters are not updated.
- CAPTURE (1 cycle): result_index<=max_index (sampled on max_valid cycle); result_match<=(max_index==latched label); total_count+=1; pass_count+=match. Counters saturate at all-ones.
  - If sweep and mem_addr != inputMemSize-1: mem_addr+1, go to FETCH.
  - Otherwise go to DONE.
- DONE: done=1, busy=0; outputs hold until next start edge.
- Abort (any state other than IDLE): next cycle state IDLE, nn_valid=0, done=0. Counters and result hold. error unchanged.
- Abort has priority over start edge and over nn_out_valid in the same cycle.
- nn_out_valid/max_valid outside RUN/WAIT_MAX are ignored.
- Minimum per-sample overhead: FETCH + CAPTURE = 2 cycles plus network latency.
- reset_n deassertion mid-run returns to IDLE with all outputs cleared. The network is reset by the same signal.

Test Plan:
1. Reset, sweep=0, sel_addr=3, label[3]=7; pulse start; network returns max_index=7 after 20 cycles -> nn_valid high 20 cycles then low; result_index=7, result_match=1, pass=1, total=1, done=1.
2. inputMemSize=4, sweep=1, labels {1,2,3,4}; network answers {1,2,0,4} -> mem_addr steps 0..3; total=4, pass=3; done after the 4th CAPTURE.
3. max_valid 3 cycles after nn_out_valid -> WAIT_MAX entered; nn_valid already 0; capture uses max_index on the max_valid cycle.
4. timeoutCycles=64, network never answers -> error=1 and done=1 at cycle 64 of RUN; nn_valid=0; total=0.
5. Abort asserted in sample 2 of a sweep -> IDLE next cycle; busy=0, done=0; total=1 retained. Next start edge clears counters.
6. start held high through a run, plus a second edge while busy -> only one run; no restart until start falls and rises again in DONE.
